// File: rtl/in_buf_tap_cal.sv
// in_buf_tap_cal: calibration controller for one buffered differential input lane.
// It sweeps every IDELAY tap while the sender drives a 1010... training pattern,
// grades each tap pass/fail, locates the longest contiguous passing run (the eye),
// and loads the eye's centre tap as the final delay.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   start             single-cycle calibration request, ignored while busy
//   idelay_rdy        IDELAYCTRL ready (clk domain); dropping it aborts a sweep
//   sample_in         delayed lane sample, registered in the clk domain
//   dly_ld, dly_tap   one-cycle load strobe and tap value for the delay primitive
//   busy, done, fail  status; done/fail held until the next accepted start
//   tap_sel           final selected tap
//   eye_start, eye_len  first tap and length of the best eye
module in_buf_tap_cal #(
  parameter int TAP_W       = 5,
  parameter int NUM_TAPS    = 32,
  parameter int SETTLE_CYC  = 16,
  parameter int WIN_CYC     = 256,
  parameter int MIN_EYE     = 3,
  parameter int DEFAULT_TAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             idelay_rdy,
  input  logic             sample_in,
  output logic             dly_ld,
  output logic [TAP_W-1:0] dly_tap,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TAP_W-1:0] tap_sel,
  output logic [TAP_W-1:0] eye_start,
  output logic [TAP_W:0]   eye_len
);

  localparam int CNT_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] DEF_TAP  = TAP_W'(DEFAULT_TAP);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_APPLY
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prev_q, prev_d;
  logic               bad_q, bad_d;
  logic [TAP_W-1:0]   cur_start_q, cur_start_d, best_start_q, best_start_d;
  logic [TAP_W:0]     cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic               dly_ld_q, dly_ld_d;
  logic [TAP_W-1:0]   dly_tap_q, dly_tap_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [TAP_W-1:0]   tap_sel_q, tap_sel_d, eye_start_q, eye_start_d;
  logic [TAP_W:0]     eye_len_q, eye_len_d;

  logic               abort;
  logic [TAP_W:0]     run_len;
  logic [TAP_W-1:0]   run_start;
  logic [TAP_W:0]     centre;

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    bad_d        = bad_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    dly_ld_d     = 1'b0;
    dly_tap_d    = dly_tap_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    tap_sel_d    = tap_sel_q;
    eye_start_d  = eye_start_q;
    eye_len_d    = eye_len_q;
    abort        = 1'b0;
    run_len      = cur_len_q;
    run_start    = cur_start_q;
    centre       = '0;

    case (state_q)
      S_IDLE: if (start) begin
        state_d      = S_WAIT_RDY;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        tap_d        = '0;
        cur_start_d  = '0;
        cur_len_d    = '0;
        best_start_d = '0;
        best_len_d   = '0;
      end
      S_WAIT_RDY: if (idelay_rdy) state_d = S_LOAD;
      S_LOAD: begin
        if (!idelay_rdy) abort = 1'b1;
        else begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (!idelay_rdy) abort = 1'b1;
        else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (!idelay_rdy) abort = 1'b1;
        else begin
          // first window cycle only seeds prev; every later cycle must toggle
          prev_d = sample_in;
          if (cnt_q != '0 && sample_in == prev_q) bad_d = 1'b1;
          if (cnt_q == CNT_W'(WIN_CYC - 1)) state_d = S_NEXT;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (!idelay_rdy) abort = 1'b1;
        else begin
          if (!bad_q) begin
            if (cur_len_q == '0) run_start = tap_q;
            run_len = cur_len_q + 1'b1;
          end
          // a run closes on a failing tap or at the end of the sweep;
          // strict compare keeps the earlier eye on a tie
          if (bad_q || tap_q == LAST_TAP) begin
            if (run_len > best_len_q) begin
              best_len_d   = run_len;
              best_start_d = run_start;
            end
            cur_len_d = '0;
          end else begin
            cur_len_d   = run_len;
            cur_start_d = run_start;
          end
          if (tap_q == LAST_TAP) state_d = S_APPLY;
          else begin
            tap_d   = tap_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_APPLY: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_APPLY;

    // strobes and results are registered on entry so they line up with
    // the LOAD / APPLY cycle itself
    if (state_d == S_LOAD) begin
      dly_ld_d  = 1'b1;
      dly_tap_d = tap_d;
    end else if (state_d == S_APPLY) begin
      dly_ld_d = 1'b1;
      if (abort) begin
        eye_start_d = '0;
        eye_len_d   = '0;
        tap_sel_d   = DEF_TAP;
        fail_d      = 1'b1;
      end else begin
        eye_start_d = best_start_d;
        eye_len_d   = best_len_d;
        centre      = {1'b0, best_start_d} + ((best_len_d - 1'b1) >> 1);
        if (best_len_d >= (TAP_W+1)'(MIN_EYE)) begin
          tap_sel_d = centre[TAP_W-1:0];
          done_d    = 1'b1;
        end else begin
          tap_sel_d = DEF_TAP;
          fail_d    = 1'b1;
        end
      end
      dly_tap_d = tap_sel_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      cnt_q        <= '0;
      prev_q       <= 1'b0;
      bad_q        <= 1'b0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      dly_ld_q     <= 1'b0;
      dly_tap_q    <= DEF_TAP;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      tap_sel_q    <= DEF_TAP;
      eye_start_q  <= '0;
      eye_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      bad_q        <= bad_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      dly_ld_q     <= dly_ld_d;
      dly_tap_q    <= dly_tap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      tap_sel_q    <= tap_sel_d;
      eye_start_q  <= eye_start_d;
      eye_len_q    <= eye_len_d;
    end
  end

  assign dly_ld    = dly_ld_q;
  assign dly_tap   = dly_tap_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign tap_sel   = tap_sel_q;
  assign eye_start = eye_start_q;
  assign eye_len   = eye_len_q;

endmodule

// File: doc/in_buf_tap_cal.md
Name: in_buf_tap_cal

Overview:
- Calibration controller for a single buffered differential input lane (IBUFDS output feeding an IDELAYE2 tap delay line).
- On request, it sweeps every delay tap while the sender drives a training clock that toggles every clk cycle (1010...).
- Each tap is graded pass/fail, and the longest contiguous run of passing taps (the "eye") is located.
- The centre tap of that eye is loaded as the final delay. Sits between the lane's input buffer/delay primitive and the board's control/status registers.

Parameters:
- TAP_W, 5, width of the tap value.
- NUM_TAPS, 32, number of taps swept (0..NUM_TAPS-1).
- SETTLE_CYC, 16, cycles ignored after each tap load.
- WIN_CYC, 256, observation cycles per tap.
- MIN_EYE, 3, minimum eye length for success.
- DEFAULT_TAP, 0, tap used after reset and on failure.

Ports:
- clk, input, 1, system clock; all logic in this domain.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle calibration request; ignored while busy.
- idelay_rdy, input, 1, IDELAYCTRL ready, synchronous to clk.
- sample_in, input, 1, delayed lane sample registered in clk domain.
- dly_ld, output, 1, one-cycle load strobe to the delay primitive.
- dly_tap, output, TAP_W, tap value presented with dly_ld; held between loads.
- busy, output, 1, high from acceptance of start until return to IDLE.
- done, output, 1, calibration succeeded; held until next accepted start or reset.
- fail, output, 1, calibration failed or aborted; held until next accepted start or reset.
- tap_sel, output, TAP_W, final selected tap.
- eye_start, output, TAP_W, first tap of the best eye.
- eye_len, output, TAP_W+1, length of the best eye (0..NUM_TAPS).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, all state returns to IDLE immediately.
- Reset values: dly_ld=0, dly_tap=DEFAULT_TAP, busy=0, done=0, fail=0, tap_sel=DEFAULT_TAP, eye_start=0, eye_len=0.
- IDLE:
  - start=1 moves to WAIT_RDY next cycle.
  - In that same transition: busy=1, done=0, fail=0, tap counter=0, run/best registers cleared.
- WAIT_RDY: wait for idelay_rdy=1, then go to LOAD. There is no timeout.
- LOAD: exactly one cycle. dly_tap=tap and dly_ld=1, then go to SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles with sample_in ignored, then goes to CHECK.
  - The first CHECK cycle is SETTLE_CYC+1 cycles after the LOAD cycle.
- CHECK:
  - Runs for WIN_CYC cycles. The first cycle only captures prev=sample_in.
  - On each later cycle, the tap is marked bad if sample_in==prev; prev is then updated.
  - The tap passes only if all WIN_CYC-1 comparisons show a transition.
  - After the window, go to NEXT.
- NEXT (one cycle), run tracking:
  - On a pass: if cur_len==0 then cur_start=tap; cur_len increments.
  - On a fail, or on a pass at tap NUM_TAPS-1: close the run. If cur_len (post-update) > best_len, copy it to best; then cur_len=0.
  - Strictly greater means that on equal lengths the earlier eye wins.
  - If tap==NUM_TAPS-1, go to APPLY; else tap+1 and go to LOAD.
- APPLY (one cycle):
  - eye_start=best_start and eye_len=best_len.
  - If best_len>=MIN_EYE: tap_sel=best_start+((best_len-1)>>1), done=1.
  - Else: tap_sel=DEFAULT_TAP, fail=1.
  - In both cases, dly_tap=tap_sel and dly_ld=1. Go to IDLE with busy=0 on the next cycle.
- Abort: idelay_rdy falling to 0 in LOAD, SETTLE, CHECK or NEXT goes to APPLY with forced failure.
  - eye_len=0, eye_start=0, tap_sel=DEFAULT_TAP, fail=1, and DEFAULT_TAP is loaded.
- Misc:
  - start pulses while busy have no effect.
  - start and APPLY never coincide, since APPLY is not IDLE.
  - dly_ld is never asserted outside LOAD and APPLY. Exactly NUM_TAPS+1 dly_ld pulses occur per full calibration.
- Arithmetic: centre-tap sum is computed at TAP_W+1 bits and cannot exceed NUM_TAPS-1. Counters are sized from clog2 of their parameter.
- Reset mid-scan: outputs immediately return to reset values; no dly_ld is issued.

Test Plan:
- Lane model passes taps 10..17 and is stuck elsewhere; pulse start -> done=1, fail=0, eye_start=10, eye_len=8, tap_sel=13, 33 dly_ld pulses total, final dly_tap=13.
- Two eyes, taps 4..8 and 20..24 (equal length 5) -> eye_start=4, tap_sel=6. Eye at taps 28..31 (runs to the end) -> eye_start=28, eye_len=4, tap_sel=29.
- All taps stuck -> fail=1, done=0, eye_len=0, tap_sel=0. Eye of 2 taps (MIN_EYE=3) -> fail=1, eye_len=2, tap_sel=0.
- A single bad sample pair inside tap 12's window, within the eye 10..17 -> tap 12 fails; best eye 13..17, eye_len=5, tap_sel=15.
- idelay_rdy=0 at start -> held in WAIT_RDY, busy=1, no dly_ld until rdy rises. idelay_rdy dropped during tap 5 CHECK -> fail=1, dly_ld with dly_tap=0, busy=0 two cycles later.
- Assert rst mid-SETTLE -> all outputs at reset values asynchronously. A start pulse during busy -> ignored (pulse count and result unchanged).
